// File: rtl/sap_sequencer.sv
// SAP-1 style control unit: owns PC, IR and the T-state machine.
// Drives the program ROM address and the datapath load/select strobes.
module sap_sequencer #(
    parameter int                ADDR_W   = 4,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [7:0]        rom_dout,
    input  logic              carry_flag,
    input  logic              zero_flag,
    output logic [ADDR_W-1:0] operand,
    output logic              acc_ld,
    output logic [1:0]        acc_sel,
    output logic              b_ld,
    output logic              alu_sub,
    output logic              flags_ld,
    output logic              out_ld,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        tstate
);

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        HALT = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_LDI = 4'h4,
        OP_JMP = 4'h5,
        OP_JC  = 4'h6,
        OP_JZ  = 4'h7,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } op_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_nx;
    logic [7:0]        ir;
    logic [7:0]        ir_nx;
    logic [3:0]        op;
    logic [ADDR_W-1:0] opr;

    logic              acc_ld_d;
    logic [1:0]        acc_sel_d;
    logic              b_ld_d;
    logic              alu_sub_d;
    logic              flags_ld_d;
    logic              out_ld_d;

    assign op  = ir[7:4];
    assign opr = ADDR_W'(ir[3:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= T0;
            pc_q  <= PC_RESET;
            ir    <= 8'h00;
        end else begin
            state <= state_nx;
            pc_q  <= pc_nx;
            ir    <= ir_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc_q;
        ir_nx      = ir;
        rom_ad     = pc_q;
        acc_ld_d   = 1'b0;
        acc_sel_d  = 2'd0;
        b_ld_d     = 1'b0;
        alu_sub_d  = 1'b0;
        flags_ld_d = 1'b0;
        out_ld_d   = 1'b0;
        unique case (state)
            T0: begin
                if (run || step) begin
                    state_nx = T1;
                end
            end
            T1: begin
                ir_nx    = rom_dout;
                pc_nx    = pc_q + ADDR_W'(1);
                state_nx = T2;
            end
            T2: begin
                state_nx = T0;
                unique case (op)
                    OP_LDA: begin
                        rom_ad   = opr;
                        acc_ld_d = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rom_ad   = opr;
                        b_ld_d   = 1'b1;
                        state_nx = T3;
                    end
                    OP_LDI: begin
                        acc_ld_d  = 1'b1;
                        acc_sel_d = 2'd2;
                    end
                    OP_JMP: pc_nx = opr;
                    OP_JC: begin
                        if (carry_flag) begin
                            pc_nx = opr;
                        end
                    end
                    OP_JZ: begin
                        if (zero_flag) begin
                            pc_nx = opr;
                        end
                    end
                    OP_OUT: out_ld_d = 1'b1;
                    OP_HLT: state_nx = HALT;
                    default: ;
                endcase
            end
            T3: begin
                acc_ld_d   = 1'b1;
                acc_sel_d  = 2'd1;
                alu_sub_d  = (op == OP_SUB);
                flags_ld_d = 1'b1;
                state_nx   = T0;
            end
            HALT: state_nx = HALT;
            default: state_nx = T0;
        endcase
    end

    // reset overrides strobes combinationally, even mid-instruction
    assign acc_ld   = acc_ld_d & ~rst;
    assign acc_sel  = rst ? 2'd0 : acc_sel_d;
    assign b_ld     = b_ld_d & ~rst;
    assign alu_sub  = alu_sub_d & ~rst;
    assign flags_ld = flags_ld_d & ~rst;
    assign out_ld   = out_ld_d & ~rst;

    assign operand = opr;
    assign halted  = (state == HALT);
    assign pc      = pc_q;
    assign tstate  = state;

endmodule

// File: tb/tb_sap_sequencer.sv
// Bench for sap_sequencer: ROM + datapath harness, ISA-level model
// feeding a scoreboard that a negedge monitor drains.
module tb_sap_sequencer;

    typedef struct packed {
        logic [2:0] ts;
        logic       acc_ld;
        logic [1:0] acc_sel;
        logic       b_ld;
        logic       alu_sub;
        logic       flags_ld;
        logic       out_ld;
        logic       halted;
        logic [3:0] rom_ad;
        logic [3:0] operand;
        logic [3:0] pc;
        logic [7:0] acc;
    } ev_t;

    typedef struct {
        int  cyc;
        ev_t e;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       run;
    logic       step;
    logic [3:0] rom_ad;
    logic [7:0] rom_dout;
    logic       carry;
    logic       zero;
    logic [3:0] operand;
    logic       acc_ld;
    logic [1:0] acc_sel;
    logic       b_ld;
    logic       alu_sub;
    logic       flags_ld;
    logic       out_ld;
    logic       halted;
    logic [3:0] pc;
    logic [2:0] tstate;

    logic [7:0] rom [16];
    logic [7:0] acc;
    logic [7:0] b;
    logic [8:0] alu;
    bit         run_a  [512];
    bit         step_a [512];
    exp_t       q [$];

    int checks;
    int failures;
    int cyc;
    int rcnt;
    logic [2:0] prev_t;
    ev_t        me;
    exp_t       mx;

    sap_sequencer #(.ADDR_W(4), .PC_RESET(4'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step       (step),
        .rom_ad     (rom_ad),
        .rom_dout   (rom_dout),
        .carry_flag (carry),
        .zero_flag  (zero),
        .operand    (operand),
        .acc_ld     (acc_ld),
        .acc_sel    (acc_sel),
        .b_ld       (b_ld),
        .alu_sub    (alu_sub),
        .flags_ld   (flags_ld),
        .out_ld     (out_ld),
        .halted     (halted),
        .pc         (pc),
        .tstate     (tstate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb rom_dout = rom[rom_ad];
    always_comb alu = {1'b0, acc} + {1'b0, (alu_sub ? ~b : b)} + {8'd0, alu_sub};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= 8'h00;
            b     <= 8'h00;
            carry <= 1'b0;
            zero  <= 1'b0;
        end else begin
            if (acc_ld) begin
                case (acc_sel)
                    2'd0:    acc <= rom_dout;
                    2'd1:    acc <= alu[7:0];
                    default: acc <= {4'h0, operand};
                endcase
            end
            if (b_ld) b <= rom_dout;
            if (flags_ld) begin
                carry <= alu[8];
                zero  <= (alu[7:0] == 8'h00);
            end
        end
    end

    // monitor: every strobe or entry to T0/HALT must match the next expectation
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if ({acc_ld, b_ld, flags_ld, out_ld} !== 4'b0000) begin
                failures++;
                $display("FAIL rst_strobes got=%b exp=0000",
                         {acc_ld, b_ld, flags_ld, out_ld});
            end
            if (rcnt == 0) begin
                checks++;
                if (q.size() != 0) begin
                    failures++;
                    $display("FAIL drain got=%0d pending exp=0", q.size());
                end
                q.delete();
            end else begin
                checks++;
                if (tstate !== 3'd0 || pc !== 4'd0 || halted !== 1'b0) begin
                    failures++;
                    $display("FAIL rst_state got=t%0d/pc%0d/h%0d exp=t0/pc0/h0",
                             tstate, pc, halted);
                end
            end
            rcnt++;
            cyc    = 0;
            prev_t = 3'd0;
        end else begin
            rcnt        = 0;
            me          = '0;
            me.ts       = tstate;
            me.acc_ld   = acc_ld;
            me.acc_sel  = acc_ld ? acc_sel : 2'd0;
            me.b_ld     = b_ld;
            me.alu_sub  = (acc_ld || flags_ld) ? alu_sub : 1'b0;
            me.flags_ld = flags_ld;
            me.out_ld   = out_ld;
            me.halted   = halted;
            me.rom_ad   = rom_ad;
            me.operand  = operand;
            me.pc       = pc;
            me.acc      = acc;
            if (acc_ld || b_ld || flags_ld || out_ld ||
                (tstate != prev_t && (tstate == 3'd0 || tstate == 3'd4))) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected cyc=%0d got=%h exp=none", cyc, me);
                end else begin
                    mx = q.pop_front();
                    if (mx.cyc != cyc || mx.e !== me) begin
                        failures++;
                        $display("FAIL event got=%h@%0d exp=%h@%0d",
                                 me, cyc, mx.e, mx.cyc);
                    end
                end
            end
            prev_t = tstate;
            cyc++;
        end
    end

    task automatic push(input int cy, input ev_t e, input int h);
        if (cy < h) q.push_back('{cy, e});
    endtask

    // instruction-level model: each instruction starts at a cycle where the
    // sequencer is idle in T0 and run|step is seen, and lasts 3 or 4 cycles
    task automatic model(input int h);
        int         idle = 0;
        int         len;
        int         s;
        bit         hlt = 0;
        bit         c = 0;
        bit         z = 0;
        logic [3:0] p = 4'd0;
        logic [3:0] np;
        logic [3:0] ad;
        logic [3:0] op;
        logic [7:0] ins;
        logic [7:0] a8 = 8'h00;
        logic [7:0] b8;
        ev_t        e;
        for (int cy = 0; cy < h; cy++) begin
            if (!hlt && cy == idle) begin
                if (run_a[cy] || step_a[cy]) begin
                    ins = rom[p];
                    op  = ins[7:4];
                    ad  = ins[3:0];
                    np  = p + 4'd1;
                    len = 3;
                    e = '0;
                    e.ts = 3'd2;
                    e.operand = ad;
                    e.pc = np;
                    e.rom_ad = np;
                    e.acc = a8;
                    case (op)
                        4'h1: begin
                            e.acc_ld = 1'b1;
                            e.rom_ad = ad;
                            push(cy + 2, e, h);
                            a8 = rom[ad];
                        end
                        4'h2, 4'h3: begin
                            e.b_ld = 1'b1;
                            e.rom_ad = ad;
                            push(cy + 2, e, h);
                            b8 = rom[ad];
                            e.b_ld = 1'b0;
                            e.rom_ad = np;
                            e.ts = 3'd3;
                            e.acc_ld = 1'b1;
                            e.acc_sel = 2'd1;
                            e.alu_sub = (op == 4'h3);
                            e.flags_ld = 1'b1;
                            push(cy + 3, e, h);
                            if (op == 4'h2) begin
                                s  = int'(a8) + int'(b8);
                                c  = (s > 255);
                                a8 = 8'(s);
                            end else begin
                                c  = (a8 >= b8);
                                a8 = a8 - b8;
                            end
                            z = (a8 == 8'h00);
                            len = 4;
                        end
                        4'h4: begin
                            e.acc_ld = 1'b1;
                            e.acc_sel = 2'd2;
                            push(cy + 2, e, h);
                            a8 = {4'h0, ad};
                        end
                        4'h5: np = ad;
                        4'h6: if (c) np = ad;
                        4'h7: if (z) np = ad;
                        4'hE: begin
                            e.out_ld = 1'b1;
                            push(cy + 2, e, h);
                        end
                        default: ;
                    endcase
                    e = '0;
                    e.operand = ad;
                    e.pc = np;
                    e.rom_ad = np;
                    e.acc = a8;
                    if (op == 4'hF) begin
                        e.ts = 3'd4;
                        e.halted = 1'b1;
                        hlt = 1'b1;
                    end
                    push(cy + len, e, h);
                    p    = np;
                    idle = cy + len;
                end else begin
                    idle = cy + 1;
                end
            end
        end
    endtask

    task automatic sched(input int h, input int run_pct, input int step_pct);
        for (int c = 0; c < h; c++) begin
            run_a[c]  = ($urandom_range(0, 99) < run_pct);
            step_a[c] = ($urandom_range(0, 99) < step_pct);
        end
    endtask

    task automatic clr_rom;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    task automatic run_case(input int h);
        model(h);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        run  = run_a[0];
        step = step_a[0];
        for (int c = 1; c < h; c++) begin
            @(posedge clk);
            #1;
            run  = run_a[c];
            step = step_a[c];
        end
        @(posedge clk);
        #1;
        rst  = 1'b1;
        run  = 1'b0;
        step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
    endtask

    logic [7:0] ops [12];

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rcnt     = 0;
        prev_t   = 3'd0;
        rst      = 1'b1;
        run      = 1'b0;
        step     = 1'b0;
        clr_rom();
        @(negedge clk);
        @(negedge clk);
        #1;

        // LDI 5 / OUT / HLT
        clr_rom();
        rom[0] = 8'h45; rom[1] = 8'hE0; rom[2] = 8'hF0;
        sched(16, 100, 0);
        run_case(16);

        // LDA 9 / ADD A / OUT / HLT
        clr_rom();
        rom[0] = 8'h19; rom[1] = 8'h2A; rom[2] = 8'hE0; rom[3] = 8'hF0;
        rom[9] = 8'h03; rom[10] = 8'h04;
        sched(20, 100, 0);
        run_case(20);

        // conditional jumps taken / not taken
        for (int k = 0; k < 4; k++) begin
            clr_rom();
            rom[0] = 8'h19;
            rom[1] = (k[0]) ? 8'h29 : 8'h39;
            rom[2] = (k[1]) ? 8'h66 : 8'h76;
            rom[3] = 8'hF0; rom[6] = 8'hE0; rom[7] = 8'hF0;
            rom[9] = 8'h05;
            sched(24, 100, 0);
            run_case(24);
        end

        // stepping with run low; the second pulse lands in T2
        clr_rom();
        sched(16, 0, 0);
        step_a[2] = 1'b1; step_a[4] = 1'b1; step_a[8] = 1'b1;
        run_case(16);

        // PC wrap through NOP at 15, then a tight JMP 15 loop
        clr_rom();
        rom[0] = 8'h5F;
        sched(20, 100, 0);
        run_case(20);
        rom[15] = 8'h5F;
        run_case(20);

        // reset while ADD sits in T3
        clr_rom();
        rom[0] = 8'h2A; rom[10] = 8'h04;
        sched(3, 100, 0);
        run_case(3);

        // random programs and run/step traffic
        ops = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50,
                8'h60, 8'h70, 8'hE0, 8'h80, 8'hC0, 8'hF0};
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 2) == 0)
                    rom[i] = 8'($urandom_range(0, 255));
                else
                    rom[i] = ops[$urandom_range(0, 11)] | 8'($urandom_range(0, 15));
            end
            if (t % 3 == 2) sched(120, 0, 25);
            else            sched(120, 75, 10);
            run_case(120);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
